// File: rtl/vga_timing_ctrl.sv
// Purpose : VGA raster sequencer; divides clk to the pixel rate and produces counters, syncs, display-enable and strobes.
// Latency : syncs/vidon are registered from next-state hc/vc, so they are aligned with hc/vc (0 cycles of decode lag).
// Backpress: none; en low parks the raster at (0,0) with syncs inactive, en high restarts it from (0,0).
module vga_timing_ctrl #(
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HSW     = 128,
    parameter int VSW     = 2,
    parameter int HBP     = 144,
    parameter int HFP     = 784,
    parameter int VBP     = 31,
    parameter int VFP     = 511,
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       vidon,
    output logic       pix_ce,
    output logic       frame_start
);

    localparam int          DW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST = 10'(HPIXELS - 1);
    localparam logic [9:0]  V_LAST = 10'(VLINES - 1);
    localparam logic [9:0]  H_SW   = 10'(HSW);
    localparam logic [9:0]  V_SW   = 10'(VSW);
    localparam logic [9:0]  H_BP   = 10'(HBP);
    localparam logic [9:0]  H_FP   = 10'(HFP);
    localparam logic [9:0]  V_BP   = 10'(VBP);
    localparam logic [9:0]  V_FP   = 10'(VFP);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    hc_q, hc_d;
    logic [9:0]    vc_q, vc_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          vidon_q, vidon_d;
    logic          fs_q, fs_d;
    logic          pix_ce_w;

    // Pixel-advance strobe is a plain decode of the registered divider.
    assign pix_ce_w = en && (div_q == DIV_LAST);

    // Next-state raster plus decode of that next state, so registered syncs line up with hc/vc.
    always_comb begin
        div_d   = div_q;
        hc_d    = hc_q;
        vc_d    = vc_q;
        fs_d    = 1'b0;
        hsync_d = 1'b1;
        vsync_d = 1'b1;
        vidon_d = 1'b0;
        if (!en) begin
            div_d = '0;
            hc_d  = '0;
            vc_d  = '0;
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
            if (pix_ce_w) begin
                if (hc_q == H_LAST) begin
                    hc_d = '0;
                    vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
                    // Only a genuine raster wrap marks a new frame; restarts via en/clr never do.
                    fs_d = (vc_q == V_LAST);
                end else begin
                    hc_d = hc_q + 10'd1;
                end
            end
            hsync_d = !(hc_d < H_SW);
            vsync_d = !(vc_d < V_SW);
            vidon_d = (hc_d >= H_BP) && (hc_d < H_FP) && (vc_d >= V_BP) && (vc_d < V_FP);
        end
    end

    // State registers; clr low forces the idle raster immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            vidon_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            vidon_q <= vidon_d;
            fs_q    <= fs_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vidon       = vidon_q;
    assign pix_ce      = pix_ce_w;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Purpose : randomized check of vga_timing_ctrl against an arithmetic raster model (reduced geometry).
// Latency : expectations are pushed at each clk edge / reset drop and popped by the monitor half a cycle later.
// Backpress: not applicable; the monitor consumes one expectation per check event.
module tb_vga_timing_ctrl;

    localparam int HP = 40;
    localparam int VL = 15;
    localparam int HS = 6;
    localparam int VS = 2;
    localparam int HB = 9;
    localparam int HF = 36;
    localparam int VB = 4;
    localparam int VF = 13;
    localparam int CD = 2;
    localparam int FRAME = HP * VL * CD;

    typedef struct packed {
        logic [9:0] hc;
        logic [9:0] vc;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       ce;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en  = 1'b1;
    logic [9:0] hc, vc;
    logic       hsync, vsync, vidon, pix_ce, frame_start;

    int   tests = 0;
    int   fails = 0;
    int   k = 0;
    int   exp_frames = 0;
    int   obs_frames = 0;
    exp_t q[$];
    event chk_ev;

    vga_timing_ctrl #(
        .HPIXELS(HP), .VLINES(VL), .HSW(HS), .VSW(VS),
        .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .CLK_DIV(CD)
    ) dut (
        .clk(clk), .clr(clr), .en(en),
        .hc(hc), .vc(vc), .hsync(hsync), .vsync(vsync),
        .vidon(vidon), .pix_ce(pix_ce), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Idle raster: after reset or while en is low.
    function automatic exp_t idle_exp();
        exp_t r;
        r = '0;
        r.hs = 1'b1;
        r.vs = 1'b1;
        return r;
    endfunction

    // After the k-th enabled edge since a restart, k/CD pixels have elapsed.
    function automatic exp_t run_exp(int kk);
        exp_t r;
        int p, h, v;
        p = kk / CD;
        h = p % HP;
        v = (p / HP) % VL;
        r.hc  = 10'(h);
        r.vc  = 10'(v);
        r.hs  = (h >= HS);
        r.vs  = (v >= VS);
        r.vid = (h >= HB) && (h < HF) && (v >= VB) && (v < VF);
        r.ce  = ((kk % CD) == CD - 1);
        r.fs  = ((kk % CD) == 0) && (p > 0) && ((p % (HP * VL)) == 0);
        return r;
    endfunction

    // Reference model: tracks enabled edges since the last restart.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            k = 0;
            q.push_back(idle_exp());
        end else if (!en) begin
            k = 0;
            q.push_back(idle_exp());
        end else begin
            k = k + 1;
            q.push_back(run_exp(k));
        end
    end

    // Monitor: compares DUT outputs against the oldest expectation.
    always begin
        exp_t e, a;
        @(negedge clk or chk_ev);
        a.hc  = hc;
        a.vc  = vc;
        a.hs  = hsync;
        a.vs  = vsync;
        a.vid = vidon;
        a.ce  = pix_ce;
        a.fs  = frame_start;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL underflow t=%0t: no expectation queued, got hc=%0d vc=%0d", $time, a.hc, a.vc);
        end else begin
            e = q.pop_front();
            exp_frames += int'(e.fs);
            obs_frames += int'(a.fs === 1'b1);
            if (a !== e) begin
                fails++;
                $display("FAIL raster t=%0t: got hc=%0d vc=%0d hs=%b vs=%b vid=%b ce=%b fs=%b, want hc=%0d vc=%0d hs=%b vs=%b vid=%b ce=%b fs=%b",
                         $time, a.hc, a.vc, a.hs, a.vs, a.vid, a.ce, a.fs,
                         e.hc, e.vc, e.hs, e.vs, e.vid, e.ce, e.fs);
            end
        end
    end

    // Advance n falling edges and settle just after, where inputs are changed.
    task automatic cycles(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Drop clr between edges, check the immediate reset state, hold, then release.
    task automatic async_reset(int hold);
        #1;
        clr = 1'b0;
        #1;
        -> chk_ev;
        cycles(hold);
        clr = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        cycles(4);
        clr = 1'b1;
        cycles(2 * FRAME + 50);
        en = 1'b0;
        cycles(10);
        en = 1'b1;
        cycles(FRAME + 300);
        async_reset(2);
        for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0, 1: cycles($urandom_range(1, FRAME));
                2: begin
                    en = 1'b0;
                    cycles($urandom_range(1, 12));
                    en = 1'b1;
                end
                default: begin
                    cycles($urandom_range(1, 200));
                    async_reset($urandom_range(1, 3));
                end
            endcase
        end
        cycles(FRAME + 10);
        cycles(2);
        tests++;
        if (obs_frames != exp_frames) begin
            fails++;
            $display("FAIL frame_count: got %0d frame_start pulses, want %0d", obs_frames, exp_frames);
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
